// File: rtl/klavye_alici.sv
// PS/2 keyboard receiver: Set 2 frames to ASCII strobe.
// Optional odd-parity check: define KLAVYE_PARITY_EN.
module klavye_alici #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] karakter,
  output logic       karakter_aktif,
  output logic       hata
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    BOSTA, VERI, DUR
  } frm_t;

  typedef enum logic [1:0] {
    NORMAL, KOPMA, GENIS, GENIS_KOPMA
  } dec_t;

  logic [1:0]    ck_s;
  logic [1:0]    dt_s;
  logic          ck_prev;
  logic          fall;
  logic          din;

  frm_t          st;
  frm_t          st_n;
  logic [3:0]    bit_cnt;
  logic [8:0]    sh;
  logic [TW-1:0] tmo;
  logic          shift_en;
  logic          frm_ok;
  logic          frm_err;
  logic          tmo_hit;
  logic          par_ok;

  logic [7:0]    byte_r;
  logic          byte_vld;
  logic          frm_err_r;

  dec_t          dec;
  dec_t          dec_n;
  logic [7:0]    asc;
  logic          hit;
  logic          emit;

  assign fall = ck_prev & ~ck_s[1];
  assign din  = dt_s[1];

`ifdef KLAVYE_PARITY_EN
  assign par_ok = ^sh;
`else
  assign par_ok = 1'b1;
`endif

  // two-flop synchronisers plus previous-clock flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_s    <= 2'b11;
      dt_s    <= 2'b11;
      ck_prev <= 1'b1;
    end else begin
      ck_s    <= {ck_s[0], ps2_clk};
      dt_s    <= {dt_s[0], ps2_data};
      ck_prev <= ck_s[1];
    end
  end

  // frame FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= BOSTA;
    else        st <= st_n;
  end

  // frame FSM next state and control strobes
  always_comb begin
    st_n     = st;
    shift_en = 1'b0;
    frm_ok   = 1'b0;
    frm_err  = 1'b0;
    tmo_hit  = 1'b0;
    unique case (st)
      BOSTA: begin
        if (fall) begin
          if (din) frm_err = 1'b1;
          else     st_n    = VERI;
        end
      end
      VERI: begin
        if (fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd8) st_n = DUR;
        end else if (tmo == TW'(TIMEOUT_CYC)) begin
          tmo_hit = 1'b1;
          st_n    = BOSTA;
        end
      end
      DUR: begin
        if (fall) begin
          st_n = BOSTA;
          if (din && par_ok) frm_ok  = 1'b1;
          else               frm_err = 1'b1;
        end else if (tmo == TW'(TIMEOUT_CYC)) begin
          tmo_hit = 1'b1;
          st_n    = BOSTA;
        end
      end
      default: st_n = BOSTA;
    endcase
  end

  // bit shifter, counters and the registered frame result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 4'd0;
      sh        <= 9'd0;
      tmo       <= '0;
      byte_r    <= 8'h00;
      byte_vld  <= 1'b0;
      frm_err_r <= 1'b0;
    end else begin
      byte_vld  <= frm_ok;
      frm_err_r <= frm_err;
      if (frm_ok) byte_r <= sh[7:0];
      if (st != VERI)    bit_cnt <= 4'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 4'd1;
      if (shift_en) sh <= {din, sh[8:1]};
      if (fall || st == BOSTA || tmo_hit) tmo <= '0;
      else                                tmo <= tmo + TW'(1);
    end
  end

  // Set 2 make code to ASCII
  always_comb begin
    asc = 8'h00;
    hit = 1'b1;
    case (byte_r)
      8'h1C: asc = 8'h61;
      8'h32: asc = 8'h62;
      8'h21: asc = 8'h63;
      8'h23: asc = 8'h64;
      8'h24: asc = 8'h65;
      8'h2B: asc = 8'h66;
      8'h34: asc = 8'h67;
      8'h33: asc = 8'h68;
      8'h43: asc = 8'h69;
      8'h3B: asc = 8'h6A;
      8'h42: asc = 8'h6B;
      8'h4B: asc = 8'h6C;
      8'h3A: asc = 8'h6D;
      8'h31: asc = 8'h6E;
      8'h44: asc = 8'h6F;
      8'h4D: asc = 8'h70;
      8'h15: asc = 8'h71;
      8'h2D: asc = 8'h72;
      8'h1B: asc = 8'h73;
      8'h2C: asc = 8'h74;
      8'h3C: asc = 8'h75;
      8'h2A: asc = 8'h76;
      8'h1D: asc = 8'h77;
      8'h22: asc = 8'h78;
      8'h35: asc = 8'h79;
      8'h1A: asc = 8'h7A;
      8'h45: asc = 8'h30;
      8'h16: asc = 8'h31;
      8'h1E: asc = 8'h32;
      8'h26: asc = 8'h33;
      8'h25: asc = 8'h34;
      8'h2E: asc = 8'h35;
      8'h36: asc = 8'h36;
      8'h3D: asc = 8'h37;
      8'h3E: asc = 8'h38;
      8'h46: asc = 8'h39;
      8'h5A: asc = 8'h0D;
      8'h66: asc = 8'h08;
      default: hit = 1'b0;
    endcase
  end

  // decoder FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec <= NORMAL;
    else        dec <= dec_n;
  end

  // decoder FSM: drop break and extended sequences
  always_comb begin
    dec_n = dec;
    emit  = 1'b0;
    if (byte_vld) begin
      unique case (dec)
        NORMAL: begin
          unique case (1'b1)
            (byte_r == 8'hF0): dec_n = KOPMA;
            (byte_r == 8'hE0): dec_n = GENIS;
            default:           emit  = hit;
          endcase
        end
        GENIS: begin
          if (byte_r == 8'hF0) dec_n = GENIS_KOPMA;
          else                 dec_n = NORMAL;
        end
        default: dec_n = NORMAL;
      endcase
    end
  end

  // output register: character strobe and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      karakter       <= 8'h00;
      karakter_aktif <= 1'b0;
      hata           <= 1'b0;
    end else begin
      karakter_aktif <= emit;
      hata           <= frm_err_r | tmo_hit;
      if (emit) karakter <= asc;
    end
  end

endmodule
